// File: rtl/seg7_scan_mux.sv
// Multiplexed 7-segment scanner: one digit slot at a time, with blanking gap,
// PWM brightness window, leading-zero suppression and frame-synchronous updates.
module seg7_scan_mux #(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 10000,
  parameter int BLANK        = 16,
  parameter int COMMON_ANODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic [2:0]            brightness,
  input  logic                  lz_blank,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   dig_en,
  output logic                  frame_tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] LAST_SLOT = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] LAST_DIG  = IW'(N_DIGITS - 1);
  localparam logic [31:0]   BLANK_W   = 32'(BLANK);
  localparam logic [31:0]   UNIT_W    = 32'((PRESCALE - BLANK) >> 3);
  localparam bit            POL       = (COMMON_ANODE != 0);

  logic [CW-1:0]         slot_cnt;
  logic [IW-1:0]         dig_idx;
  logic [2:0]            b_hold;
  logic [2:0]            b_eff;
  logic [4*N_DIGITS-1:0] disp_digits;
  logic [4*N_DIGITS-1:0] pend_digits;
  logic [N_DIGITS-1:0]   disp_dp;
  logic [N_DIGITS-1:0]   pend_dp;
  logic                  pend_valid;

  logic                  slot_wrap;
  logic                  frame_end;
  logic [31:0]           cnt_w;
  logic [31:0]           win_len;
  logic                  in_win;
  logic                  zero_run;
  logic [N_DIGITS-1:0]   supp;
  logic [3:0]            nib;
  logic                  cur_dp;
  logic                  cur_supp;
  logic [N_DIGITS-1:0]   onehot;

  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [N_DIGITS-1:0]   en_d;
  logic                  tick_d;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [N_DIGITS-1:0]   en_q;
  logic                  tick_q;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_wrap = ena && (slot_cnt == LAST_SLOT);
    frame_end = slot_wrap && (dig_idx == LAST_DIG);
    // brightness is live on the first slot cycle, then held for the rest of the slot
    b_eff     = (slot_cnt == '0) ? brightness : b_hold;
    cnt_w     = 32'(slot_cnt);
    win_len   = UNIT_W * (32'(b_eff) + 32'd1);
    in_win    = (cnt_w >= BLANK_W) && (cnt_w < BLANK_W + win_len);
  end

  // Walk from the most significant digit down; a digit is suppressible while
  // every nibble from the top down to it is zero. Digit 0 always shows.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (disp_digits[4*(N_DIGITS-1-j) +: 4] != 4'h0) zero_run = 1'b0;
      supp[N_DIGITS-1-j] = zero_run && (j != N_DIGITS - 1);
    end
  end

  always_comb begin
    nib      = '0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    onehot   = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (dig_idx == IW'(i)) begin
        nib       = disp_digits[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_supp  = supp[i];
        onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_d  = '0;
    dp_d   = 1'b0;
    en_d   = '0;
    tick_d = 1'b0;
    if (ena) begin
      tick_d = (slot_cnt == '0) && (dig_idx == '0);
      if (in_win) begin
        en_d  = onehot;
        dp_d  = cur_dp;
        seg_d = (lz_blank && cur_supp) ? 7'h00 : hex7(nib);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
      b_hold   <= '0;
    end else begin
      if (slot_cnt == '0) b_hold <= brightness;
      if (ena) begin
        if (slot_wrap) begin
          slot_cnt <= '0;
          dig_idx  <= (dig_idx == LAST_DIG) ? '0 : dig_idx + 1'b1;
        end else begin
          slot_cnt <= slot_cnt + 1'b1;
        end
      end
    end
  end

  // A load on the frame edge itself bypasses pending so the newest data wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_digits <= '0;
      disp_dp     <= '0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        disp_digits <= digits_in;
        disp_dp     <= dp_in;
      end else if (pend_valid) begin
        disp_digits <= pend_digits;
        disp_dp     <= pend_dp;
      end
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_digits <= digits_in;
      pend_dp     <= dp_in;
      pend_valid  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= '0;
      dp_q   <= 1'b0;
      en_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      en_q   <= en_d;
      tick_q <= tick_d;
    end
  end

  assign seg_out    = seg_q ^ {7{POL}};
  assign dp_out     = dp_q ^ POL;
  assign dig_en     = en_q ^ {N_DIGITS{POL}};
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized bench for seg7_scan_mux against a frame-position reference model;
// a common-anode copy runs on the same stimulus.
module tb_seg7_scan_mux;

  localparam int N     = 4;
  localparam int P     = 64;
  localparam int B     = 8;
  localparam int FRAME = N * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [2:0]  brightness = '0;

  logic [6:0] a_seg, c_seg;
  logic       a_dp, c_dp;
  logic [3:0] a_en, c_en;
  logic       a_tick, c_tick;

  seg7_scan_mux #(.N_DIGITS(N), .PRESCALE(P), .BLANK(B), .COMMON_ANODE(0)) dut_cc (
    .clk(clk), .rst_n(rst_n), .ena(ena), .digits_in(digits_in), .dp_in(dp_in),
    .load(load), .brightness(brightness), .lz_blank(lz_blank),
    .seg_out(a_seg), .dp_out(a_dp), .dig_en(a_en), .frame_tick(a_tick));

  seg7_scan_mux #(.N_DIGITS(N), .PRESCALE(P), .BLANK(B), .COMMON_ANODE(1)) dut_ca (
    .clk(clk), .rst_n(rst_n), .ena(ena), .digits_in(digits_in), .dp_in(dp_in),
    .load(load), .brightness(brightness), .lz_blank(lz_blank),
    .seg_out(c_seg), .dp_out(c_dp), .dig_en(c_en), .frame_tick(c_tick));

  always #50 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: position within the frame, shown/pending data, slot brightness
  int          m_pos = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_dpd = '0, m_dpp = '0;
  bit          m_pv = 1'b0;
  logic [2:0]  m_b = '0;
  logic [6:0]  e_seg = '0;
  logic        e_dp = 1'b0;
  logic [3:0]  e_en = '0;
  logic        e_tick = 1'b0;
  int          mc, md, mw;
  logic [2:0]  mb;
  logic [15:0] upper;

  task model_reset();
    m_pos = 0; m_disp = '0; m_pend = '0; m_dpd = '0; m_dpp = '0; m_pv = 1'b0; m_b = '0;
    e_seg = '0; e_dp = 1'b0; e_en = '0; e_tick = 1'b0;
  endtask

  task model_edge();
    mc = m_pos % P;
    md = m_pos / P;
    e_seg = '0; e_dp = 1'b0; e_en = '0; e_tick = 1'b0;
    if (ena) begin
      mb = (mc == 0) ? brightness : m_b;
      mw = ((P - B) / 8) * (int'(mb) + 1);
      e_tick = (m_pos == 0);
      if (mc >= B && mc < B + mw) begin
        e_en  = 4'(1 << md);
        e_dp  = m_dpd[md];
        upper = m_disp >> (4 * md);
        if (!(lz_blank && md > 0 && upper == 16'h0)) e_seg = seg_tab[upper[3:0]];
      end
    end
    if (mc == 0) m_b = brightness;
    if (ena && m_pos == FRAME - 1) begin
      if (load) begin
        m_disp = digits_in; m_dpd = dp_in;
      end else if (m_pv) begin
        m_disp = m_pend; m_dpd = m_dpp;
      end
      m_pv = 1'b0;
    end else if (load) begin
      m_pend = digits_in; m_dpp = dp_in; m_pv = 1'b1;
    end
    if (ena) m_pos = (m_pos + 1) % FRAME;
  endtask

  task step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("out_cc", {a_tick, a_dp, a_en, a_seg}, {e_tick, e_dp, e_en, e_seg});
    check_eq("out_ca", {c_tick, c_dp, c_en, c_seg}, {e_tick, ~e_dp, ~e_en, ~e_seg});
  endtask

  task run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task load_val(input logic [15:0] d, input logic [3:0] dp);
    digits_in = d; dp_in = dp; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task wait_pos(input int target);
    int n;
    n = 0;
    while (m_pos != target && n < 2 * FRAME) begin step(); n++; end
    if (m_pos != target) check_eq("wait_pos_reached", m_pos, target);
  endtask

  task wait_tick(output int n);
    n = 0;
    do begin step(); n++; end while (!a_tick && n < 4 * FRAME);
    if (!a_tick) check_eq("tick_seen", a_tick, 1);
  endtask

  int n, on_cnt;

  initial begin
    ena = 1'b1; brightness = 3'd7;
    repeat (3) @(negedge clk);
    check_eq("reset_cc", {a_tick, a_dp, a_en, a_seg}, 13'h0000);
    check_eq("reset_ca", {c_tick, c_dp, c_en, c_seg}, 13'h0FFF);
    rst_n = 1'b1;

    // full brightness, frame tick spacing
    load_val(16'h1234, 4'h0);
    wait_tick(n);
    wait_tick(n);
    check_eq("tick_period", n, FRAME);
    wait_pos(B + 3);
    check_eq("digit0_seg_1234", a_seg, 7'h66);
    check_eq("digit0_seg_ca", c_seg, 7'h19);
    run(FRAME);

    // brightness window widths
    brightness = 3'd0;
    run(2 * FRAME);
    brightness = 3'd3;
    wait_tick(n);
    wait_tick(n);
    on_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (a_en != 4'h0) on_cnt++;
      step();
    end
    check_eq("on_cycles_b3", on_cnt, 4 * 28);
    brightness = 3'd7;

    // leading-zero suppression
    lz_blank = 1'b1;
    load_val(16'h0050, 4'h0);
    run(2 * FRAME);
    load_val(16'h0000, 4'b0100);
    run(2 * FRAME);
    lz_blank = 1'b0;

    // tear-free: mid-frame load, then a load on the frame edge over a pending value
    load_val(16'h1234, 4'h0);
    run(2 * FRAME);
    wait_pos(P + 10);
    load_val(16'hAAAA, 4'h0);
    run(2 * FRAME);
    wait_pos(2 * P);
    load_val(16'hBBBB, 4'h0);
    wait_pos(FRAME - 1);
    load_val(16'hCCCC, 4'h0);
    wait_pos(B + 5);
    check_eq("bypass_seg", a_seg, 7'h39);
    run(FRAME);

    // freeze mid-window
    wait_pos(P + 20);
    ena = 1'b0;
    run(100);
    ena = 1'b1;
    run(FRAME);

    // asynchronous reset mid-window
    wait_pos(2 * P + 30);
    #10 rst_n = 1'b0;
    #1;
    check_eq("async_rst_cc", {a_tick, a_dp, a_en, a_seg}, 13'h0000);
    check_eq("async_rst_ca", {c_tick, c_dp, c_en, c_seg}, 13'h0FFF);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin step(); n++; end while (a_en == 4'h0 && n < 300);
    check_eq("first_en_cycle", n, B + 1);
    check_eq("first_en_value", a_en, 4'b0001);

    // randomized traffic
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        digits_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_in = 4'($urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) brightness = 3'($urandom);
      if ($urandom_range(0, 299) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 99) == 0) ena = ~ena;
      step();
    end
    load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Downstream display stage for the hex digit counter and its 7-segment decode.
- Takes N packed hex nibbles and time-multiplexes them onto one shared 7-segment bus with one-hot digit enables, from the 10 MHz system clock.
- Adds anti-ghosting blanking, 8-level PWM brightness, leading-zero suppression, and tear-free updates at frame boundaries.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
PRESCALE, 10000, clk cycles per digit slot (1 kHz per digit at 10 MHz); must be ≥ BLANK+8
BLANK, 16, cycles at start of each slot with all enables off
COMMON_ANODE, 0, 1 inverts seg_out, dp_out and dig_en at the pins

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  scan enable; 0 freezes counters and blanks outputs
digits_in  input  4*N_DIGITS  hex nibbles, digit 0 (rightmost) at [3:0]
dp_in  input  N_DIGITS  decimal point per digit
load  input  1  capture digits_in/dp_in into the pending register
brightness  input  3  on-time level 0..7
lz_blank  input  1  enable leading-zero suppression
seg_out  output  7  segments a..g, bit0=a
dp_out  output  1  decimal point
dig_en  output  N_DIGITS  one-hot digit enable
frame_tick  output  1  one-cycle pulse at frame start

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. On reset:
  - slot_cnt=0, dig_idx=0.
  - Display and pending registers = 0, pending_valid=0.
  - frame_tick=0; seg_out, dp_out and dig_en at the inactive level (0, or all-ones when COMMON_ANODE=1).
- Timing: all outputs are registered, with one cycle of lag relative to the internal counters. Logic below is stated active-high; polarity inversion applies at the output only.
- Slot counter: slot_cnt counts 0..PRESCALE-1.
  - At wrap, dig_idx increments, 0 → N_DIGITS-1 → 0.
  - Scan order is digit 0 first.
- Slot window: W = ((PRESCALE-BLANK)>>3)*(b+1), where b is brightness sampled at slot_cnt==0 and held for the slot.
  - dig_en[dig_idx]=1 only while BLANK ≤ slot_cnt < BLANK+W; all other dig_en bits are 0.
  - seg_out and dp_out are valid during the window and 0 outside it.
- Decode, bit0=a. 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero suppression (lz_blank=1): digit i (i≥1) is suppressed when its nibble and all higher nibbles are 0.
  - seg_out=0 for a suppressed digit; dp_out is still honoured and dig_en still follows the window.
  - Digit 0 is never suppressed.
- load: the sampled value goes to the pending register and sets pending_valid; a later load overwrites it.
- Frame boundary: the edge where slot_cnt wraps with dig_idx=N_DIGITS-1.
  - If pending_valid, the display register takes the pending value and pending_valid clears.
  - If load is high on that same edge, digits_in/dp_in go directly to the display register (bypass), newest data wins.
  - frame_tick pulses in the first cycle of the new frame.
  - The display never changes mid-frame.
- ena=0:
  - slot_cnt and dig_idx hold; outputs go inactive on the next edge; frame_tick=0.
  - load is still captured into pending.
  - On ena=1 scanning resumes from the held counts.
- Reset mid-slot: outputs go inactive immediately, without waiting for a clock edge. After release, scanning starts at digit 0 with a full BLANK period.

Test Plan (PRESCALE=64, BLANK=8, COMMON_ANODE=0 unless noted):
- Reset: assert rst_n=0 mid-window → seg_out=00, dig_en=0000, frame_tick=0 before the next clk edge. After release, the first dig_en assertion is 0001 at slot cycle 8.
- Full brightness: load digits_in=0x1234, b=7 → from the frame after frame_tick:
  - digit-0 slot: dig_en=0000 for 8 cycles, then 0001 with seg_out=66 for 56 cycles.
  - digit 3: seg_out=06.
  - frame_tick period 256 cycles.
- Brightness: b=0 → dig_en high 7 cycles per slot; b=3 → 28 cycles.
- Leading-zero suppression, lz_blank=1:
  - 0x0050 → digits 3 and 2 show seg_out=00 (enable still pulses), digit 1=6D, digit 0=3F.
  - 0x0000 → only digit 0 shows 3F.
  - dp_in=0100 with 0x0000 → dp_out=1 during the digit-2 window.
- Tear-free update:
  - Load 0xAAAA at the digit-1 slot → display remains 0x1234 until frame_tick, then shows 77 per digit.
  - Load on the boundary edge with pending 0xBBBB → new frame shows the digits_in value, not 0xBBBB.
- Freeze and polarity:
  - ena=0 for 100 cycles mid-window → outputs inactive; on ena=1 the window resumes at the held slot_cnt.
  - COMMON_ANODE=1: reset gives seg_out=7F, dig_en=1111, and the digit-0 slot shows seg_out=~66=19.
